// File: rtl/mips_pkg.sv
// Shared definitions for the multi-port MIPS register file and its clear sequencer.
package mips_pkg;

    // Architectural register that may be hardwired to zero
    localparam int REG_ZERO   = 0;

    // Default geometry: 32 registers of 32 bits
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Bulk-clear sequencer state encoding
    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

endpackage : mips_pkg

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks a pointer over every register address, one per
// cycle, and reports progress with a busy level and a one-cycle done pulse.
module regfile_clr_seq
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    // Last address of the array; termination is on this value, not on wrap
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, pointer and registered-output computation
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_RUN;
                    ptr_d   = '0;
                end else begin
                    state_d = CLR_IDLE;
                end
            end
            CLR_RUN: begin
                ptr_d = ptr_q + PTR_ONE;
                if (ptr_q == PTR_LAST) begin
                    state_d = CLR_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CLR_RUN;
                end
            end
            default: begin
                state_d = CLR_IDLE;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == CLR_RUN);
    end

    // State, pointer and status flops; reset aborts any sequence without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy = busy_q;
    assign clr_done = done_q;
    assign clr_en   = (state_q == CLR_RUN);
    assign clr_addr = ptr_q;

endmodule : regfile_clr_seq

// File: rtl/mips_regfile_mp.sv
// Parametrised multi-port register file: NUM_RD combinational read ports, two
// write ports (port 1 wins on collision), optional write-through bypass,
// optional hardwired zero register and a bulk-clear sequencer.
module mips_regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic              clr_en_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              wr0_ok_s;
    logic              wr1_ok_s;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_en   (clr_en_s),
        .clr_addr (clr_addr_s)
    );

    // External writes are dropped while clearing and, if hardwired, to register 0
    assign wr0_ok_s = we0 && !clr_en_s && !((ZERO_REG != 0) && (waddr0 == ZERO_ADDR));
    assign wr1_ok_s = we1 && !clr_en_s && !((ZERO_REG != 0) && (waddr1 == ZERO_ADDR));

    // Array next value: clear slot, else port 0 then port 1 so port 1 wins a collision
    always_comb begin
        regs_d = regs_q;
        if (clr_en_s) begin
            regs_d[clr_addr_s] = '0;
        end else begin
            if (wr0_ok_s) begin
                regs_d[waddr0] = wdata0;
            end else begin
                regs_d[waddr0] = regs_q[waddr0];
            end
            if (wr1_ok_s) begin
                regs_d[waddr1] = wdata1;
            end else begin
                regs_d[waddr1] = regs_d[waddr1];
            end
        end
    end

    // Register array storage; reset zeroes every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = raddr[k*ADDR_W +: ADDR_W];

        // Read mux: zero register, then bypass (port 1 first), then array contents
        always_comb begin
            if ((ZERO_REG != 0) && (ra_s == ZERO_ADDR)) begin
                rd_s = '0;
            end else if ((BYPASS != 0) && wr1_ok_s && (waddr1 == ra_s)) begin
                rd_s = wdata1;
            end else if ((BYPASS != 0) && wr0_ok_s && (waddr0 == ra_s)) begin
                rd_s = wdata0;
            end else begin
                rd_s = regs_q[ra_s];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_s;
    end

endmodule : mips_regfile_mp
